// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesting units and rr_resource_arbiter.
// The master side drives req/done, and the slave (the arbiter) returns grant, sel and status.
interface rr_resource_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    grant;
    logic [SELW-1:0] sel;
    logic            sel_valid;
    logic            busy;
    logic            timeout;

    modport master (
        output req, done,
        input  grant, sel, sel_valid, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, sel, sel_valid, busy, timeout
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner arbiter for a shared mux-tree datapath. It produces a registered one-hot grant and a binary select.
// Defining ARB_TIMEOUT_EN adds a grant-hold limit of MAX_HOLD cycles. When the limit is hit, the arbiter revokes the grant and pulses timeout.
module rr_resource_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rr_resource_arbiter_if.slave  bus
);
    localparam int unsigned SELW = $clog2(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("rr_resource_arbiter: N must be in 2..8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_resource_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic            rel;
    logic            expire;
    logic [SELW-1:0] nxt_ptr;
    logic [SELW:0]   pick_res;

    // First requester at or after base, wrapping mod N; MSB flags that one was found.
    function automatic logic [SELW:0] pick(input logic [N-1:0] r, input logic [SELW-1:0] base);
        logic [SELW:0] res;
        int unsigned   idx;
        res = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(base) + k) % N;
            if (!res[SELW] && r[SELW'(idx)]) begin
                res = {1'b1, SELW'(idx)};
            end
        end
        return res;
    endfunction

    assign rel     = bus.done[owner_q] | ~bus.req[owner_q];
    assign nxt_ptr = SELW'((32'(owner_q) + 32'd1) % N);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    // Hold counter restarts on every grant (including a re-grant) and counts unreleased cycles.
    always_comb begin
        hold_d = hold_q;
        if (state_d == GRANTED && (state_q == IDLE || rel || expire)) begin
            hold_d = '0;
        end else if (state_q == GRANTED) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign expire = (state_q == GRANTED) && (hold_q == HOLD_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state plus next registered outputs; a release re-arbitrates in the same cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        pick_res  = '0;

        case (state_q)
            IDLE: begin
                pick_res = pick(bus.req, ptr_q);
                if (pick_res[SELW]) begin
                    state_d = GRANTED;
                    owner_d = pick_res[SELW-1:0];
                end
            end
            GRANTED: begin
                if (rel || expire) begin
                    ptr_d     = nxt_ptr;
                    timeout_d = ~rel;
                    pick_res  = pick(bus.req, nxt_ptr);
                    if (pick_res[SELW]) begin
                        owner_d = pick_res[SELW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // sel holds its last value in IDLE so the mux inputs do not toggle.
        grant_d = '0;
        sel_d   = sel_q;
        busy_d  = 1'b0;
        if (state_d == GRANTED) begin
            grant_d[owner_d] = 1'b1;
            sel_d            = owner_d;
            busy_d           = 1'b1;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = busy_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed vector table, corner sequences and random traffic against a reference model.
// It follows ARB_TIMEOUT_EN in the same way as the design.
module tb_rr_resource_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    rr_resource_arbiter_if #(.N(N)) bus ();

    rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model: owner index, rotating pointer, hold age and last select.
    int m_busy, m_owner, m_ptr, m_sel, m_hold, m_to;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int winner(input int r, input int p);
        for (int k = 0; k < N; k++) begin
            if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_sel = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_step(input int r, input int d);
        bit rl, ex;
        m_to = 0;
        if (m_busy == 0) begin
            if (r != 0) begin
                m_owner = winner(r, m_ptr);
                m_busy  = 1;
                m_hold  = 0;
                m_sel   = m_owner;
            end
        end else begin
            rl = (((d >> m_owner) & 1) != 0) || (((r >> m_owner) & 1) == 0);
            ex = TO_EN && !rl && (m_hold == MAX_HOLD - 1);
            if (rl || ex) begin
                m_to  = ex ? 1 : 0;
                m_ptr = (m_owner + 1) % N;
                if (r != 0) begin
                    m_owner = winner(r, m_ptr);
                    m_hold  = 0;
                    m_sel   = m_owner;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".grant"},     32'(bus.grant),     (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
        check({tag, ".sel"},       32'(bus.sel),       32'(m_sel));
        check({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(m_busy));
        check({tag, ".busy"},      32'(bus.busy),      32'(m_busy));
        check({tag, ".timeout"},   32'(bus.timeout),   32'(m_to));
    endtask

    // Drive at the falling edge, let one rising edge happen, then sample at the next falling edge.
    task automatic cycle(input int r, input int d, input string tag);
        bus.req  = 4'(r);
        bus.done = 4'(d);
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        compare_model(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r, d;
        n_pass = 0;
        n_total = 0;

        //            req      done     grant    sel  busy
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b1};
        tbl[4]  = '{4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1};
        tbl[5]  = '{4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1};
        tbl[6]  = '{4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{4'b0110, 4'b0010, 4'b0100, 2'd2, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[10] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1};
        tbl[11] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[12] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

        reset_n  = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_model("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(int'(tbl[i].req), int'(tbl[i].done), $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.grant", i), 32'(bus.grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d.sel", i),   32'(bus.sel),   32'(tbl[i].sel));
            check($sformatf("tbl%0d.busy", i),  32'(bus.busy),  32'(tbl[i].busy));
        end

        // Reset asserted while owner 2 holds the grant takes effect without a clock edge.
        cycle(4'b0100, 0, "pre_rst");
        check("pre_rst.grant", 32'(bus.grant), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst.grant", 32'(bus.grant), 32'h0);
        check("mid_rst.sel",   32'(bus.sel),   32'h0);
        check("mid_rst.busy",  32'(bus.busy),  32'h0);
        model_reset();
        bus.req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(4'b0001, 0, "post_rst");
        check("post_rst.grant", 32'(bus.grant), 32'h1);

        // Owner 0 never releases while requester 1 waits.
        if (TO_EN) begin
            for (int c = 1; c <= 5; c++) begin
                cycle(4'b0011, 0, $sformatf("hold%0d", c));
                check($sformatf("hold%0d.timeout", c), 32'(bus.timeout), (c == 4) ? 32'd1 : 32'd0);
                check($sformatf("hold%0d.grant", c),   32'(bus.grant),   (c >= 4) ? 32'h2 : 32'h1);
            end
        end else begin
            for (int c = 1; c <= 100; c++) begin
                cycle(4'b0011, 0, $sformatf("hold%0d", c));
                check($sformatf("hold%0d.timeout", c), 32'(bus.timeout), 32'd0);
                check($sformatf("hold%0d.grant", c),   32'(bus.grant),   32'h1);
            end
        end
        cycle(0, 0, "drain");

        // Random traffic: requests persist for a while, and done is mostly aimed at the owner.
        r = 0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if (((r >> b) & 1) != 0) begin
                    if ($urandom_range(0, 7) == 0) r &= ~(1 << b);
                end else if ($urandom_range(0, 3) == 0) begin
                    r |= (1 << b);
                end
            end
            d = 0;
            if (m_busy != 0 && $urandom_range(0, 3) == 0) d = 1 << m_owner;
            if ($urandom_range(0, 4) == 0) d |= int'($urandom_range(0, 15));
            cycle(r, d, $sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
